// File: rtl/mmm_pkg.sv
// Shared core parameters and branch-queue types used by the fetch/execute
// branch tracking logic.
package mmm_pkg;

    localparam int XLEN   = 32;
    localparam int HLEN   = 10;
    localparam int OFFSET = 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [HLEN-1:0] index;
    } bpq_entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } brq_state_t;

endpackage

// File: rtl/bpq_fifo.sv
// Circular buffer of in-flight branch entries with push, pop and a clear
// that empties the queue by collapsing head onto tail.
module bpq_fifo
    import mmm_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   push_i,
    input  bpq_entry_t             push_data_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    output bpq_entry_t             head_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PW = $clog2(DEPTH);

    bpq_entry_t    mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + PW'(1);
            if (pop_i)  head_d = head_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[head_q];
    assign count_o     = count_q;
    assign full_o      = (count_q == (PW+1)'(DEPTH));
    assign empty_o     = (count_q == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch tracker: matches fetch predictions with execute outcomes,
// drives the predictor update port and raises mispredict/redirect.
module branch_resolve_queue
    import mmm_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            pred_valid_i,
    output logic            pred_ready_o,
    input  logic [XLEN-1:0] pred_pc_i,
    input  logic            pred_taken_i,
    input  logic [HLEN-1:0] pred_index_i,
    input  logic            res_valid_i,
    output logic            res_ready_o,
    input  logic            res_taken_i,
    input  logic [XLEN-1:0] res_target_i,
    output logic            upd_valid_o,
    output logic [HLEN-1:0] upd_index_o,
    output logic            upd_taken_o,
    output logic            mispredict_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output brq_state_t      dbg_state_o
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high at the rising edge; ready never depends on the matching valid.

    brq_state_t            state_q, state_d;
    logic                  upd_valid_q, upd_valid_d;
    logic [HLEN-1:0]       upd_index_q, upd_index_d;
    logic                  upd_taken_q, upd_taken_d;
    logic                  mispredict_q, mispredict_d;
    logic [XLEN-1:0]       redirect_pc_q, redirect_pc_d;

    bpq_entry_t            push_entry;
    bpq_entry_t            head_entry;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  fifo_full, fifo_empty;
    logic                  fifo_push, fifo_pop, fifo_clear;
    logic                  push_fire, pop_fire, mis;

    assign push_entry = '{pc: pred_pc_i, taken: pred_taken_i, index: pred_index_i};

    bpq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .clear_i     (fifo_clear),
        .head_data_o (head_entry),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        pred_ready_o  = 1'b0;
        res_ready_o   = 1'b0;
        upd_valid_d   = 1'b0;
        upd_index_d   = upd_index_q;
        upd_taken_d   = upd_taken_q;
        mispredict_d  = 1'b0;
        redirect_pc_d = redirect_pc_q;

        if (state_q == RUN) begin
            pred_ready_o = !fifo_full;
            res_ready_o  = !fifo_empty;
        end

        push_fire = pred_valid_i && pred_ready_o;
        pop_fire  = res_valid_i && res_ready_o;
        mis       = pop_fire && (head_entry.taken != res_taken_i);

        // A mispredict squashes younger entries, including one arriving now.
        fifo_clear = flush_i || mis;
        fifo_push  = push_fire && !fifo_clear;
        fifo_pop   = pop_fire && !fifo_clear;

        case (state_q)
            RUN:     if (mis) state_d = RECOVER;
            RECOVER: state_d = RUN;
            default: state_d = RUN;
        endcase

        if (pop_fire && !flush_i) begin
            upd_valid_d = 1'b1;
            upd_index_d = head_entry.index;
            upd_taken_d = res_taken_i;
        end
        if (mis && !flush_i) begin
            mispredict_d  = 1'b1;
            redirect_pc_d = res_taken_i ? res_target_i : head_entry.pc + XLEN'(4);
        end

        if (flush_i) state_d = RUN;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= RUN;
            upd_valid_q   <= 1'b0;
            upd_index_q   <= '0;
            upd_taken_q   <= 1'b0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            upd_valid_q   <= upd_valid_d;
            upd_index_q   <= upd_index_d;
            upd_taken_q   <= upd_taken_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign upd_valid_o   = upd_valid_q;
    assign upd_index_o   = upd_index_q;
    assign upd_taken_o   = upd_taken_q;
    assign mispredict_o  = mispredict_q;
    assign redirect_pc_o = redirect_pc_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: a reference queue model predicts
// readiness and the registered update/mispredict outputs one cycle later.
module tb_branch_resolve_queue;
    import mmm_pkg::*;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [HLEN-1:0] index;
        logic            taken;
        logic            mis;
        logic [XLEN-1:0] redirect;
    } exp_t;

    logic            clk_i = 1'b0;
    logic            rst_n_i = 1'b0;
    logic            flush_i = 1'b0;
    logic            pred_valid_i = 1'b0;
    logic            pred_ready_o;
    logic [XLEN-1:0] pred_pc_i = '0;
    logic            pred_taken_i = 1'b0;
    logic [HLEN-1:0] pred_index_i = '0;
    logic            res_valid_i = 1'b0;
    logic            res_ready_o;
    logic            res_taken_i = 1'b0;
    logic [XLEN-1:0] res_target_i = '0;
    logic            upd_valid_o;
    logic [HLEN-1:0] upd_index_o;
    logic            upd_taken_o;
    logic            mispredict_o;
    logic [XLEN-1:0] redirect_pc_o;
    brq_state_t      dbg_state_o;

    int n_checks = 0;
    int n_errors = 0;

    exp_t       exp_q[$];
    bpq_entry_t mdl_q[$];
    brq_state_t mdl_state = RUN;

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .flush_i       (flush_i),
        .pred_valid_i  (pred_valid_i),
        .pred_ready_o  (pred_ready_o),
        .pred_pc_i     (pred_pc_i),
        .pred_taken_i  (pred_taken_i),
        .pred_index_i  (pred_index_i),
        .res_valid_i   (res_valid_i),
        .res_ready_o   (res_ready_o),
        .res_taken_i   (res_taken_i),
        .res_target_i  (res_target_i),
        .upd_valid_o   (upd_valid_o),
        .upd_index_o   (upd_index_o),
        .upd_taken_o   (upd_taken_o),
        .mispredict_o  (mispredict_o),
        .redirect_pc_o (redirect_pc_o),
        .dbg_state_o   (dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pred_ready"}, 64'(pred_ready_o), 64'd1);
        check({tag, "_res_ready"}, 64'(res_ready_o), 64'd0);
        check({tag, "_upd_valid"}, 64'(upd_valid_o), 64'd0);
        check({tag, "_upd_index"}, 64'(upd_index_o), 64'd0);
        check({tag, "_upd_taken"}, 64'(upd_taken_o), 64'd0);
        check({tag, "_mispredict"}, 64'(mispredict_o), 64'd0);
        check({tag, "_redirect"}, 64'(redirect_pc_o), 64'd0);
        check({tag, "_state"}, 64'(dbg_state_o), 64'(RUN));
    endtask

    // Drives one cycle from a negedge, checks readiness against the model,
    // advances the model at the edge and scores the registered outputs.
    task automatic drive_cycle(input logic pv, input logic [XLEN-1:0] pc, input logic pt,
                               input logic [HLEN-1:0] pidx, input logic rv, input logic rt,
                               input logic [XLEN-1:0] tgt, input logic fl);
        logic       m_pr, m_rr, mis;
        bpq_entry_t e;
        exp_t       x;
        pred_valid_i = pv;
        pred_pc_i    = pc;
        pred_taken_i = pt;
        pred_index_i = pidx;
        res_valid_i  = rv;
        res_taken_i  = rt;
        res_target_i = tgt;
        flush_i      = fl;
        #1;
        m_pr = (mdl_state == RUN) && (mdl_q.size() < DEPTH);
        m_rr = (mdl_state == RUN) && (mdl_q.size() > 0);
        check("pred_ready", 64'(pred_ready_o), 64'(m_pr));
        check("res_ready", 64'(res_ready_o), 64'(m_rr));
        check("state", 64'(dbg_state_o), 64'(mdl_state));

        if (fl) begin
            mdl_q.delete();
            mdl_state = RUN;
        end else begin
            mis = 1'b0;
            if (rv && m_rr) begin
                e = mdl_q.pop_front();
                mis = (e.taken != rt);
                x.index    = e.index;
                x.taken    = rt;
                x.mis      = mis;
                x.redirect = rt ? tgt : e.pc + 32'd4;
                exp_q.push_back(x);
            end
            if (mis) begin
                mdl_q.delete();
                mdl_state = RECOVER;
            end else begin
                if (pv && m_pr) mdl_q.push_back('{pc: pc, taken: pt, index: pidx});
                mdl_state = RUN;
            end
        end

        @(posedge clk_i);
        #1;
        if (upd_valid_o) begin
            if (exp_q.size() == 0) begin
                check("upd_unexpected", 64'(upd_valid_o), 64'd0);
            end else begin
                x = exp_q.pop_front();
                check("upd_index", 64'(upd_index_o), 64'(x.index));
                check("upd_taken", 64'(upd_taken_o), 64'(x.taken));
                check("mispredict", 64'(mispredict_o), 64'(x.mis));
                if (x.mis) check("redirect_pc", 64'(redirect_pc_o), 64'(x.redirect));
            end
        end else begin
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("upd_valid", 64'(upd_valid_o), 64'd1);
            end
            check("mispredict_idle", 64'(mispredict_o), 64'd0);
        end
        @(negedge clk_i);
        pred_valid_i = 1'b0;
        res_valid_i  = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic push_only(input logic [XLEN-1:0] pc, input logic pt, input logic [HLEN-1:0] pidx);
        drive_cycle(1'b1, pc, pt, pidx, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic resolve_only(input logic rt, input logic [XLEN-1:0] tgt);
        drive_cycle(1'b0, '0, 1'b0, '0, 1'b1, rt, tgt, 1'b0);
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        #1;
        check_reset_outputs("reset");
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Correct prediction updates the predictor without mispredict.
        push_only(32'h100, 1'b1, 10'h05);
        resolve_only(1'b1, 32'h180);
        idle_cycle();

        // Taken predicted, not taken actual: fall-through redirect, then wrap.
        push_only(32'h200, 1'b1, 10'h11);
        resolve_only(1'b0, 32'h999);
        idle_cycle();
        push_only(32'hFFFF_FFFC, 1'b1, 10'h12);
        resolve_only(1'b0, 32'h777);
        idle_cycle();

        // Oldest of three mispredicts taken; same-cycle push is squashed.
        push_only(32'h300, 1'b0, 10'h21);
        push_only(32'h304, 1'b1, 10'h22);
        push_only(32'h308, 1'b0, 10'h23);
        drive_cycle(1'b1, 32'h50C, 1'b0, 10'h24, 1'b1, 1'b1, 32'h400, 1'b0);
        drive_cycle(1'b1, 32'h510, 1'b0, 10'h25, 1'b1, 1'b0, '0, 1'b0);
        drive_cycle(1'b1, 32'h400, 1'b0, 10'h26, 1'b0, 1'b0, '0, 1'b0);
        resolve_only(1'b0, '0);
        idle_cycle();

        // Fill to DEPTH; a push with a concurrent pop at full is refused.
        for (int i = 0; i < DEPTH; i++) push_only(32'h1000 + 32'(i * 4), 1'b1, 10'(8'h40 + i));
        drive_cycle(1'b1, 32'h2000, 1'b1, 10'h3FF, 1'b1, 1'b1, 32'h5000, 1'b0);
        push_only(32'h2004, 1'b1, 10'h3FE);
        for (int i = 0; i < DEPTH; i++) resolve_only(1'b1, 32'h6000);
        idle_cycle();

        // Flush beats a same-cycle resolution.
        for (int i = 0; i < 4; i++) push_only(32'h3000 + 32'(i * 4), 1'b0, 10'(8'h60 + i));
        drive_cycle(1'b1, 32'h3100, 1'b0, 10'h70, 1'b1, 1'b1, 32'h3200, 1'b1);
        resolve_only(1'b0, '0);

        // Resolution attempts on an empty queue do nothing.
        resolve_only(1'b1, 32'h8000);
        resolve_only(1'b0, 32'h8004);

        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                        10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 3) != 0), $urandom,
                        1'($urandom_range(0, 40) == 0));
        end

        // Asynchronous reset while an update is being presented.
        for (int i = 0; i < 3; i++) push_only(32'h9000 + 32'(i * 4), 1'b1, 10'(8'h80 + i));
        resolve_only(1'b0, 32'hA000);
        check("pre_reset_upd_valid", 64'(upd_valid_o), 64'd1);
        rst_n_i = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        #1;
        rst_n_i = 1'b1;
        mdl_q.delete();
        exp_q.delete();
        mdl_state = RUN;
        @(negedge clk_i);
        push_only(32'hB000, 1'b0, 10'h0F);
        resolve_only(1'b0, '0);
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
